// File: rtl/seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : seq_pkg                                                |
// | Shared state encoding, default width and length clamp helper.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package seq_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_e;

    // A zero or oversized request length means a full-width pattern.
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
        if (len == 0 || len > width) begin
            return width;
        end
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_pattern_tx_piso_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : piso_reg                                               |
// | Parallel-load shift-left register with reload copy and next tap. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module piso_reg #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             reload_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [LEN_W-1:0] tap_idx_i,
    output logic             tap_d_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] copy_q;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (reload_i) begin
            sr_d = copy_q;
        end else if (shift_i) begin
            sr_d = {sr_q[WIDTH-2:0], 1'b0};
        end
    end

    // Tap of the next register value, so the caller can register the serial bit.
    always_comb begin
        tap_d_o = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (tap_idx_i == LEN_W'(i)) begin
                tap_d_o = sr_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q   <= '0;
            copy_q <= '0;
        end else begin
            sr_q <= sr_d;
            if (load_i) begin
                copy_q <= data_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : seq_pattern_tx                                         |
// | Serial MSB-first pattern transmitter with repeat and done pulse. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic [REP_W-1:0] load_rep,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   bit_q, bit_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [LEN_W-1:0]   len_eff;
    logic               load_en, reload_en, shift_en;
    logic               tap_d;
    logic               out_q, out_valid_q, busy_q, done_q, load_ready_q;

    assign len_eff = LEN_W'(eff_len(32'(load_len), 32'(WIDTH)));

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        bit_d     = bit_q;
        rep_d     = rep_q;
        load_en   = 1'b0;
        reload_en = 1'b0;
        shift_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid && load_ready_q) begin
                    state_d = SHIFT;
                    len_d   = len_eff;
                    bit_d   = len_eff - LEN_W'(1);
                    rep_d   = load_rep;
                    load_en = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_q != '0) begin
                    bit_d    = bit_q - LEN_W'(1);
                    shift_en = 1'b1;
                end else if (rep_q != '0) begin
                    // Back-to-back pass: reload in place of the shift, no gap cycle.
                    bit_d     = len_q - LEN_W'(1);
                    rep_d     = rep_q - REP_W'(1);
                    reload_en = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    piso_reg #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_piso (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load_en),
        .reload_i  (reload_en),
        .shift_i   (shift_en),
        .data_i    (load_data),
        .tap_idx_i (len_d - LEN_W'(1)),
        .tap_d_o   (tap_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            bit_q        <= '0;
            rep_q        <= '0;
            out_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            bit_q        <= bit_d;
            rep_q        <= rep_d;
            out_q        <= (state_d == SHIFT) ? tap_d : 1'b0;
            out_valid_q  <= (state_d == SHIFT);
            busy_q       <= (state_d == SHIFT);
            done_q       <= (state_d == DONE);
            load_ready_q <= (state_d == IDLE);
        end
    end

    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_ready = load_ready_q;

endmodule
`default_nettype wire
